// File: rtl/stopwatch_if.sv
// stopwatch_if: button levels in, display values and status pulses out of the stopwatch timebase
//   master: drives start_stop, clear (and lap when STOPWATCH_LAP_EN is defined); reads outputs
//   slave : the timebase; reads buttons, drives seconds[5:0], minutes[5:0], running, sec_tick, rollover
interface stopwatch_if;
  logic start_stop;
  logic clear;
`ifdef STOPWATCH_LAP_EN
  logic lap;
`endif
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic running;
  logic sec_tick;
  logic rollover;
`ifdef STOPWATCH_LAP_EN
  modport master(output start_stop, clear, lap, input seconds, minutes, running, sec_tick, rollover);
  modport slave(input start_stop, clear, lap, output seconds, minutes, running, sec_tick, rollover);
`else
  modport master(output start_stop, clear, input seconds, minutes, running, sec_tick, rollover);
  modport slave(input start_stop, clear, output seconds, minutes, running, sec_tick, rollover);
`endif
endinterface

// File: rtl/stopwatch_timebase.sv
// stopwatch_timebase: 1 Hz prescaler plus minutes:seconds counters under an IDLE/RUN/PAUSE FSM
//   clk, rst (async, active-high); sw (stopwatch_if.slave): start_stop, clear, [lap] in;
//   seconds, minutes, running, sec_tick, rollover out (all from flops).
//   Macro STOPWATCH_LAP_EN adds the lap button and a held snapshot of the display values.
module stopwatch_timebase #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int MAX_MIN = 59
) (
  input logic clk,
  input logic rst,
  stopwatch_if.slave sw
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state;
  logic [PW-1:0] pre;
  logic [5:0] sec_cnt, min_cnt;
  logic [1:0] ss_sync, cl_sync;
  logic ss_prev, cl_prev;
  logic run_q, tick_q, roll_q;
  logic ss_edge, cl_edge, term;
  assign ss_edge = ss_sync[1] & ~ss_prev;
  assign cl_edge = cl_sync[1] & ~cl_prev;
  assign term = (state == RUN) && (pre == PW'(TICKS_PER_SEC - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ss_sync <= '0;
      cl_sync <= '0;
      ss_prev <= 1'b0;
      cl_prev <= 1'b0;
      state <= IDLE;
      pre <= '0;
      sec_cnt <= '0;
      min_cnt <= '0;
      run_q <= 1'b0;
      tick_q <= 1'b0;
      roll_q <= 1'b0;
    end else begin
      ss_sync <= {ss_sync[0], sw.start_stop};
      cl_sync <= {cl_sync[0], sw.clear};
      ss_prev <= ss_sync[1];
      cl_prev <= cl_sync[1];
      if (cl_edge) begin
        state <= IDLE;
        pre <= '0;
        sec_cnt <= '0;
        min_cnt <= '0;
        run_q <= 1'b0;
        tick_q <= 1'b0;
        roll_q <= 1'b0;
      end else begin
        // a start_stop edge on the terminal count still lets that tick land
        state <= ss_edge ? (state == RUN ? PAUSE : RUN) : state;
        run_q <= ss_edge ? (state != RUN) : (state == RUN);
        tick_q <= term;
        roll_q <= term && sec_cnt == 6'd59 && min_cnt == 6'(MAX_MIN);
        if (state == RUN) pre <= term ? '0 : pre + 1'b1;
        if (term) begin
          sec_cnt <= sec_cnt == 6'd59 ? 6'd0 : sec_cnt + 6'd1;
          if (sec_cnt == 6'd59) min_cnt <= min_cnt == 6'(MAX_MIN) ? 6'd0 : min_cnt + 6'd1;
        end
      end
    end
`ifdef STOPWATCH_LAP_EN
  logic [1:0] lap_sync;
  logic lap_prev, hold;
  logic [5:0] snap_sec, snap_min;
  logic lap_edge;
  assign lap_edge = lap_sync[1] & ~lap_prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lap_sync <= '0;
      lap_prev <= 1'b0;
      hold <= 1'b0;
      snap_sec <= '0;
      snap_min <= '0;
    end else begin
      lap_sync <= {lap_sync[0], sw.lap};
      lap_prev <= lap_sync[1];
      if (cl_edge) hold <= 1'b0;
      else if (lap_edge && state != IDLE) begin
        hold <= ~hold;
        snap_sec <= sec_cnt;
        snap_min <= min_cnt;
      end
    end
  assign sw.seconds = hold ? snap_sec : sec_cnt;
  assign sw.minutes = hold ? snap_min : min_cnt;
`else
  assign sw.seconds = sec_cnt;
  assign sw.minutes = min_cnt;
`endif
  assign sw.running = run_q;
  assign sw.sec_tick = tick_q;
  assign sw.rollover = roll_q;
endmodule
